// File: rtl/mips_rf_write_arbiter.sv
// Register-file write-port arbiter: ALU writeback has priority, multi-cycle results
// wait in a 2-entry FIFO, and a starvation limit briefly stalls the ALU for the FIFO head.
module mips_rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wr_en,
    input  logic [4:0]  alu_wr_addr,
    input  logic [31:0] alu_wr_data,
    output logic        alu_stall,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy_mask,
    output logic [1:0]  fifo_count
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    function automatic logic [31:0] onehot32(input logic [4:0] a);
        onehot32 = 32'd1 << a;
    endfunction

    logic [1:0]  live_r;
    logic [4:0]  addr_r [2];
    logic [31:0] data_r [2];
    logic        head_r;
    logic        tail_r;
    logic [1:0]  count_r;
    logic [3:0]  starve_r;

    logic head_valid_s;
    logic head_live_s;
    logic starve_hit_s;
    logic alu_eff_s;
    logic grant_head_s;
    logic pop_s;
    logic enq_s;
    logic any_live_s;
    logic new_live_s;

    // Grant decision, handshake and FIFO control strobes
    always_comb begin
        head_valid_s = (count_r != 2'd0);
        head_live_s  = head_valid_s & live_r[head_r];
        starve_hit_s = rst & head_live_s & (starve_r == LIMIT);
        alu_stall    = starve_hit_s;
        alu_eff_s    = rst & alu_wr_en & (alu_wr_addr != 5'd0) & ~starve_hit_s;
        grant_head_s = rst & head_live_s & ~alu_eff_s;
        // A killed head leaves without touching the port, even while the ALU writes.
        pop_s        = rst & head_valid_s & (grant_head_s | ~live_r[head_r]);
        mc_ready     = rst & (count_r != 2'd2);
        enq_s        = mc_valid & mc_ready & (mc_addr != 5'd0);
        any_live_s   = |live_r;
        // A same-cycle mc transfer is older than the ALU write, so it is born dead on a match.
        new_live_s   = ~(alu_eff_s & (mc_addr == alu_wr_addr));
    end

    // Register-file write port mux
    always_comb begin
        rf_we    = alu_eff_s | grant_head_s;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (alu_eff_s) begin
            rf_waddr = alu_wr_addr;
            rf_wdata = alu_wr_data;
        end else if (grant_head_s) begin
            rf_waddr = addr_r[head_r];
            rf_wdata = data_r[head_r];
        end else begin
            rf_waddr = 5'd0;
            rf_wdata = 32'd0;
        end
    end

    // Hazard-unit busy mask and occupancy, both from registered state only
    always_comb begin
        busy_mask  = 32'd0;
        fifo_count = 2'd0;
        if (rst) begin
            fifo_count = count_r;
            for (int i = 0; i < 2; i++) begin
                if (live_r[i]) begin
                    busy_mask = busy_mask | onehot32(addr_r[i]);
                end else begin
                    busy_mask = busy_mask;
                end
            end
        end else begin
            fifo_count = 2'd0;
        end
    end

    // FIFO storage, pointers, count and WAW kill of live entries
    always_ff @(posedge clk) begin
        if (!rst) begin
            live_r  <= 2'b00;
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                addr_r[i] <= 5'd0;
                data_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (alu_eff_s && (addr_r[i] == alu_wr_addr)) begin
                    live_r[i] <= 1'b0;
                end
            end
            if (pop_s) begin
                live_r[head_r] <= 1'b0;
                head_r         <= ~head_r;
            end
            if (enq_s) begin
                live_r[tail_r] <= new_live_s;
                addr_r[tail_r] <= mc_addr;
                data_r[tail_r] <= mc_data;
                tail_r         <= ~tail_r;
            end
            count_r <= count_r + {1'b0, enq_s} - {1'b0, pop_s};
        end
    end

    // Starvation counter: counts ALU wins over a live head, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_r <= 4'd0;
        end else if (!any_live_s || grant_head_s) begin
            starve_r <= 4'd0;
        end else if (head_live_s && alu_eff_s && (starve_r != LIMIT)) begin
            starve_r <= starve_r + 4'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: doc/mips_rf_write_arbiter.md
# mips_rf_write_arbiter

Shares the single write port of the MIPS register file between the in-order ALU writeback path and a multi-cycle writeback source (loads, mult/div results). ALU writes pass straight through with priority. Multi-cycle results enter a 2-entry FIFO through a valid/ready handshake and drain when the write port is free. A bounded-starvation rule briefly stalls the ALU writer, and a busy mask of queued destinations feeds the hazard unit.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may lose the port before the ALU is stalled (1..15).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset is synchronous and active-low (asserted when 0).
- alu_wr_en  in  1  ALU writeback request this cycle.
- alu_wr_addr  in  5  ALU destination register.
- alu_wr_data  in  32  ALU write data.
- alu_stall  out  1  ALU write not taken this cycle; upstream holds alu_wr_* stable.
- mc_valid  in  1  multi-cycle result offered.
- mc_ready  out  1  FIFO can accept; transfer on mc_valid & mc_ready.
- mc_addr  in  5  multi-cycle destination register.
- mc_data  in  32  multi-cycle write data.
- rf_we  out  1  register-file write enable (drives RegWrite).
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- busy_mask  out  32  bit r set when a live FIFO entry targets register r.
- fifo_count  out  2  occupied FIFO slots (0..2), live or killed.

## Operation
- FIFO: 2 entries {live, addr, data}, head/tail pointers, count.
- Enqueue on mc_valid & mc_ready. An mc_addr of 0 is accepted and discarded; nothing is enqueued.
- mc_ready = rst & (fifo_count < 2). It ignores a same-cycle dequeue.
- ALU write is "effective" when alu_wr_en & alu_wr_addr != 0 & !alu_stall. A $0 ALU request never uses the port and never counts as a grant.
- Grant priority each cycle:
  - If the starvation counter equals STARVE_LIMIT and the head is live, alu_stall=1 and the head is written.
  - Otherwise an effective ALU write wins.
  - Otherwise a live head is written.
- Killed head: popped in any cycle without using the port, including cycles where the ALU writes.
- rf_* outputs are combinational from the grant. rf_we=0 when nothing is granted, and rf_waddr/rf_wdata are then don't-care.
- WAW kill: an effective ALU write to address R clears the live flag of every FIFO entry with addr R, including an entry enqueued that same cycle. Same-cycle mc transfers are treated as older than the ALU write. A stalled ALU write kills nothing.
- Starvation counter:
  - Increments when the head is live and the ALU wins.
  - Clears when a live head is written, or when the FIFO holds no live entry.
  - Saturates at STARVE_LIMIT.
- busy_mask = OR over live entries of onehot(addr). Registered state only; a same-cycle enqueue appears next cycle.

## Timing
- Reset (rst=0 at posedge): count=0, all live flags=0, pointers=0, starvation counter=0.
- While rst=0: rf_we=0, alu_stall=0, mc_ready=0, busy_mask=0, fifo_count=0.
- Reset mid-operation discards queued entries; nothing is written.
- ALU path latency: 0 cycles (same-cycle rf_we).
- Multi-cycle path latency: minimum 1 cycle. Enqueue at edge N; rf_we for that entry no earlier than cycle N+1.
- Full FIFO: mc_ready=0 for the whole cycle even if the head drains.
- alu_stall lasts exactly one cycle per starvation event. The counter clears the same cycle the head is written.

## Test plan
- Reset, then ALU writes addr 5, data 0xDEADBEEF -> rf_we=1, rf_waddr=5 the same cycle. mc_ready=1. busy_mask=0.
- mc transfers {addr 8, 0x11} with no ALU traffic -> fifo_count=1 and busy_mask[8]=1 next cycle. rf_we=1, rf_waddr=8, rf_wdata=0x11 that cycle. Count returns to 0.
- Fill FIFO with {9,0xA},{10,0xB} while the ALU writes continuously to addr 3 -> mc_ready=0 while full. After 4 ALU grants, alu_stall=1 for one cycle and addr 9 is written. Counter then restarts and addr 10 follows after 4 more.
- Queue {12,0x55}, then ALU writes 12 with 0x99 -> busy_mask[12] clears. The entry pops with rf_we=0 (any ALU write to another address proceeds). The register file ends holding 0x99.
- The same cycle the mc writer transfers {7,0x1}, the ALU writes 7 with 0x2 -> the entry is killed and never written. The final value is 0x2.
- mc_addr=0 and ALU addr 0 offered together -> rf_we=0, fifo_count stays 0, alu_stall=0. Assert rst=0 with 2 entries queued -> count=0 next cycle and no writes issue.
